lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Memory-stage load/store controller. It sits between the MEM pipeline stage and the data-bus slave, and directly upstream of the load sign/zero-extension logic. It turns a MEM-stage load or store into a single bus transaction with byte enables and lane-replicated store data, and stalls the pipeline until the slave acknowledges. It then presents the raw read word, address and funct3 to the load extension logic.

## Interface
- TIMEOUT, 255: maximum cycles in REQ without `i_bus_ack` before the access is abandoned (1..65535).
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous and active-high.
- i_mem_valid  in  1  MEM stage holds a valid instruction.
- i_is_load  in  1  the instruction is a load.
- i_is_store  in  1  the instruction is a store.
- i_funct3  in  3  RV32I load/store funct3.
- i_addr  in  32  effective byte address.
- i_wdata  in  32  store data (rs2).
- o_stall  out  1  freeze PC and IF/ID/EX/MEM registers.
- o_done  out  1  one-cycle pulse: the access has completed.
- o_rdata  out  32  raw read word, held until the next access completes.
- o_addr  out  32  byte address of the completed access.
- o_funct3  out  3  funct3 of the completed access.
- o_is_load  out  1  the completed access was a load.
- o_err  out  1  the completed access timed out or was misaligned; valid with `o_done`.
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  32  word-aligned address, `{i_addr[31:2],2'b00}`.
- o_bus_be  out  4  byte enables.
- o_bus_wdata  out  32  lane-replicated store data.
- i_bus_ack  in  1  slave accepted the write, or read data is valid.
- i_bus_rdata  in  32  read data, sampled with `i_bus_ack`.

## Operation
- FSM states: IDLE, REQ, DONE. Reset enters IDLE.
- **IDLE**
  - Start condition is `i_mem_valid & (i_is_load | i_is_store)`.
  - On start, register the address, funct3, load/store flag, byte enables and store data, then go to REQ.
  - If both load and store are set, treat the access as a load.
- **REQ**
  - `o_bus_req`=1 and all bus outputs are held stable.
  - The cycle counter starts at 0 and increments each REQ cycle.
  - On `i_bus_ack`: capture `i_bus_rdata` (loads only) and go to DONE with err=0.
  - If the counter reaches TIMEOUT-1 with no ack: drop the request, set o_rdata=0 and go to DONE with err=1.
- **DONE**
  - `o_done`=1 and `o_stall`=0, so the pipeline advances at the end of this cycle.
  - Always go to IDLE; `i_mem_valid` is ignored in DONE because it still shows the same instruction.
- **Byte enables and store data**
  - SB: be = `4'b0001 << i_addr[1:0]`; wdata = byte replicated ×4.
  - SH: be = `addr[1] ? 4'b1100 : 4'b0011`; wdata = halfword replicated ×2.
  - SW: be = `4'b1111`.
  - Loads: be = `4'b1111`, we=0.
  - These lane rules match the downstream extractor: byte by `addr[1:0]`, halfword by `addr[1]`.
- **Ack handling:** `i_bus_ack` outside REQ is ignored.

## Timing
- Reset values: state=IDLE, and every output is 0 (o_rdata, o_addr, o_funct3, bus outputs, o_done, o_err, o_stall).
- Reset mid-REQ drops `o_bus_req` immediately, asynchronously.
- `o_stall` = (IDLE & start) | REQ. It is combinational from the start condition and is high in the request cycle.
- Minimum occupancy is 3 cycles when the ack arrives in the first REQ cycle: accept, REQ, DONE. That is 2 stall cycles.
- With the ack arriving in REQ cycle k (1-based), occupancy is k+2 cycles.
- o_rdata, o_addr, o_funct3 and o_is_load update at the REQ→DONE edge and hold until the next completion.
- Stores leave o_rdata at 0.
- Back-to-back accesses: DONE → IDLE → accept. One non-stalled cycle always separates two accesses.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:**
  - Misaligned accesses are LH/LHU/SH with `addr[0]`=1, and LW/SW with `addr[1:0]`≠0.
  - A misaligned access skips REQ and goes IDLE→DONE.
  - No bus request is issued, o_err=1 and o_rdata=0.
- **Not defined:**
  - No alignment check is made; the access is issued with the byte enables above.
  - LW/SW ignore `addr[1:0]`; halfwords use `addr[1]` only.
  - o_err is set only by timeout.

## Test plan
- **LW with immediate ack:** addr 0x104, ack in the first REQ cycle with rdata 0xDEADBEEF → be=1111, we=0, o_stall high for 2 cycles, o_done in cycle 3, o_rdata=0xDEADBEEF, o_addr=0x104, o_err=0.
- **SB:** addr 0x203, wdata 0x000000A5, ack after 3 REQ cycles → o_bus_addr=0x200, be=1000, o_bus_wdata=0xA5A5A5A5, we=1, stall for 4 cycles.
- **SH and LHU:** SH at 0x2 with wdata 0x1234 → be=1100, o_bus_wdata=0x12341234. LHU at 0x0 → be=1111, o_funct3=101.
- **Timeout:** TIMEOUT=4, load with ack never asserted → req high for exactly 4 cycles, then o_done=1, o_err=1, o_rdata=0.
- **Asynchronous reset mid-REQ:** assert i_rst in REQ cycle 2 → o_bus_req and o_stall go low immediately; after release a new LW is accepted normally.
- **Misaligned LW at 0x101:**
  - With `LSU_MISALIGN_TRAP_EN`: o_bus_req never asserted, o_done on the next cycle, o_err=1.
  - Without the macro: bus access issued to 0x100 with be=1111, o_err=0.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: memory-stage load/store controller.
// Turns a MEM-stage load or store into one data-bus transaction with byte enables and
// lane-replicated store data, stalls the pipeline until the slave acks (or the access
// times out), then presents the raw read word, address and funct3 for load extension.
//
// Build option: define LSU_MISALIGN_TRAP_EN to complete misaligned halfword/word
// accesses immediately with o_err=1 and no bus request.

module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_valid,
    input  logic        i_is_load,
    input  logic        i_is_store,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic [31:0] o_addr,
    output logic [2:0]  o_funct3,
    output logic        o_is_load,
    output logic        o_err,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    // Last counter value allowed in REQ before the access is abandoned.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

    state_e      state_q, state_d;

    // Access captured at accept time; drives the bus while in REQ.
    logic [31:0] acc_addr_q;
    logic [2:0]  acc_funct3_q;
    logic        acc_load_q;
    logic        acc_we_q;
    logic [3:0]  acc_be_q;
    logic [31:0] acc_wdata_q;
    logic [15:0] cnt_q;

    // Completion results presented downstream.
    logic [31:0] rdata_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        is_load_q;
    logic        err_q;

    logic        start;
    logic        misalign;
    logic        timeout_hit;
    logic        in_req;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;

    assign start       = i_mem_valid & (i_is_load | i_is_store);
    assign timeout_hit = (cnt_q == TimeoutLast);
    assign in_req      = (state_q == StReq);

`ifdef LSU_MISALIGN_TRAP_EN
    // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
    always_comb begin
        misalign = 1'b0;
        if (i_funct3[1:0] == 2'b01) begin
            misalign = i_addr[0];
        end else if (i_funct3[1:0] == 2'b10) begin
            misalign = (i_addr[1:0] != 2'b00);
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Byte enables and lane-replicated store data; a load wins if both flags are set.
    always_comb begin
        be_new    = 4'b1111;
        wdata_new = 32'h0;
        if (!i_is_load) begin
            case (i_funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << i_addr[1:0];
                    wdata_new = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    be_new    = i_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{i_wdata[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = i_wdata;
                end
            endcase
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = misalign ? StDone : StReq;
                end
            end
            StReq: begin
                if (i_bus_ack || timeout_hit) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                // MEM still shows the finished instruction here, so never re-accept.
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the access on accept and count cycles spent in REQ.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc_addr_q   <= 32'h0;
            acc_funct3_q <= 3'b000;
            acc_load_q   <= 1'b0;
            acc_we_q     <= 1'b0;
            acc_be_q     <= 4'b0000;
            acc_wdata_q  <= 32'h0;
            cnt_q        <= 16'h0;
        end else if (state_q == StIdle) begin
            cnt_q <= 16'h0;
            if (start) begin
                acc_addr_q   <= i_addr;
                acc_funct3_q <= i_funct3;
                acc_load_q   <= i_is_load;
                acc_we_q     <= ~i_is_load;
                acc_be_q     <= be_new;
                acc_wdata_q  <= wdata_new;
            end
        end else if (in_req) begin
            cnt_q <= cnt_q + 16'h1;
        end
    end

    // Completion results; held until the next access completes.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_q   <= 32'h0;
            addr_q    <= 32'h0;
            funct3_q  <= 3'b000;
            is_load_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (in_req && (i_bus_ack || timeout_hit)) begin
            // Ack takes priority over a timeout landing in the same cycle.
            rdata_q   <= (i_bus_ack && acc_load_q) ? i_bus_rdata : 32'h0;
            addr_q    <= acc_addr_q;
            funct3_q  <= acc_funct3_q;
            is_load_q <= acc_load_q;
            err_q     <= ~i_bus_ack;
        end else if ((state_q == StIdle) && start && misalign) begin
            rdata_q   <= 32'h0;
            addr_q    <= i_addr;
            funct3_q  <= i_funct3;
            is_load_q <= i_is_load;
            err_q     <= 1'b1;
        end
    end

    // Bus outputs are gated by REQ so reset drops them without waiting for a clock.
    always_comb begin
        o_bus_req   = in_req;
        o_bus_we    = in_req & acc_we_q;
        o_bus_addr  = in_req ? {acc_addr_q[31:2], 2'b00} : 32'h0;
        o_bus_be    = in_req ? acc_be_q : 4'b0000;
        o_bus_wdata = in_req ? acc_wdata_q : 32'h0;
    end

    // Pipeline handshake and result outputs.
    always_comb begin
        o_stall   = ((state_q == StIdle) && start) || in_req;
        o_done    = (state_q == StDone);
        o_rdata   = rdata_q;
        o_addr    = addr_q;
        o_funct3  = funct3_q;
        o_is_load = is_load_q;
        o_err     = err_q;
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: the driver pushes expected bus and completion records,
// a negedge monitor (which also plays the bus slave) pops and compares them.
module tb_lsu_mem_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_mem_valid, i_is_load, i_is_store;
    logic [2:0]  i_funct3;
    logic [31:0] i_addr, i_wdata;
    logic        o_stall, o_done, o_is_load, o_err;
    logic [31:0] o_rdata, o_addr;
    logic [2:0]  o_funct3;
    logic        o_bus_req, o_bus_we;
    logic [31:0] o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_be;
    logic        i_bus_ack;
    logic [31:0] i_bus_rdata;

    lsu_mem_ctrl #(.TIMEOUT(4)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_mem_valid (i_mem_valid),
        .i_is_load   (i_is_load),
        .i_is_store  (i_is_store),
        .i_funct3    (i_funct3),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .o_stall     (o_stall),
        .o_done      (o_done),
        .o_rdata     (o_rdata),
        .o_addr      (o_addr),
        .o_funct3    (o_funct3),
        .o_is_load   (o_is_load),
        .o_err       (o_err),
        .o_bus_req   (o_bus_req),
        .o_bus_we    (o_bus_we),
        .o_bus_addr  (o_bus_addr),
        .o_bus_be    (o_bus_be),
        .o_bus_wdata (o_bus_wdata),
        .i_bus_ack   (i_bus_ack),
        .i_bus_rdata (i_bus_rdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic        ld;
        logic        err;
        int          stall;
        int          req;
    } done_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } bus_t;

    done_t       done_q[$];
    bus_t        bus_q[$];
    bus_t        cur_bus;
    int          checks = 0;
    int          errors = 0;
    int          slv_delay = 0;     // ack in this REQ cycle (1-based); 0 = never
    logic [31:0] slv_rdata = 32'h0;
    int          stall_cnt = 0;
    int          req_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor and bus slave, sampling on the falling edge.
    initial begin
        done_t d;
        i_bus_ack   = 1'b0;
        i_bus_rdata = 32'h0;
        forever begin
            @(negedge i_clk);
            if (i_rst) begin
                stall_cnt = 0;
                req_cnt   = 0;
                i_bus_ack = 1'b0;
            end else begin
                if (o_stall) stall_cnt++;
                if (o_bus_req) begin
                    if (req_cnt == 0) begin
                        if (bus_q.size() == 0) begin
                            chk("unexpected_bus_req", 32'd1, 32'd0);
                        end else begin
                            cur_bus = bus_q.pop_front();
                        end
                    end
                    req_cnt++;
                    chk("bus_addr", o_bus_addr, cur_bus.addr);
                    chk("bus_be", {28'h0, o_bus_be}, {28'h0, cur_bus.be});
                    chk("bus_wdata", o_bus_wdata, cur_bus.wdata);
                    chk("bus_we", {31'h0, o_bus_we}, {31'h0, cur_bus.we});
                    if (req_cnt == slv_delay) begin
                        i_bus_ack   = 1'b1;
                        i_bus_rdata = slv_rdata;
                    end else begin
                        i_bus_ack   = 1'b0;
                        i_bus_rdata = 32'hBAD0BAD0;
                    end
                end else begin
                    i_bus_ack = 1'b0;
                end
                if (o_done) begin
                    if (done_q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        d = done_q.pop_front();
                        chk("rdata", o_rdata, d.rdata);
                        chk("addr", o_addr, d.addr);
                        chk("funct3", {29'h0, o_funct3}, {29'h0, d.f3});
                        chk("is_load", {31'h0, o_is_load}, {31'h0, d.ld});
                        chk("err", {31'h0, o_err}, {31'h0, d.err});
                        chk("stall_cycles", stall_cnt, d.stall);
                        chk("req_cycles", req_cnt, d.req);
                        chk("stall_in_done", {31'h0, o_stall}, 32'd0);
                    end
                    stall_cnt = 0;
                    req_cnt   = 0;
                end
            end
        end
    end

    task automatic run(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                       input logic [31:0] srd, input logic exp_bus, input logic [31:0] e_baddr,
                       input logic [3:0] e_be, input logic [31:0] e_bwd, input logic e_we,
                       input logic e_err, input logic [31:0] e_rd, input int e_stall,
                       input int e_req);
        done_t d;
        bus_t  b;
        bit    seen;
        d = '{rdata: e_rd, addr: addr, f3: f3, ld: ld, err: e_err, stall: e_stall, req: e_req};
        b = '{addr: e_baddr, wdata: e_bwd, be: e_be, we: e_we};
        done_q.push_back(d);
        if (exp_bus) bus_q.push_back(b);
        slv_delay = delay;
        slv_rdata = srd;
        @(posedge i_clk);
        #1;
        i_mem_valid = 1'b1;
        i_is_load   = ld;
        i_is_store  = st;
        i_funct3    = f3;
        i_addr      = addr;
        i_wdata     = wdata;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge i_clk);
            if (o_done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        @(posedge i_clk);
        #1;
        i_mem_valid = 1'b0;
        i_is_load   = 1'b0;
        i_is_store  = 1'b0;
    endtask

    initial begin
        i_rst = 1'b1;
        i_mem_valid = 1'b0;
        i_is_load = 1'b0;
        i_is_store = 1'b0;
        i_funct3 = 3'b000;
        i_addr = 32'h0;
        i_wdata = 32'h0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_stall", {31'h0, o_stall}, 32'd0);
        chk("rst_done", {31'h0, o_done}, 32'd0);
        chk("rst_bus_req", {31'h0, o_bus_req}, 32'd0);
        chk("rst_rdata", o_rdata, 32'd0);
        chk("rst_addr", o_addr, 32'd0);
        chk("rst_err", {31'h0, o_err}, 32'd0);
        chk("rst_bus_be", {28'h0, o_bus_be}, 32'd0);
        i_rst = 1'b0;

        // ld st f3 addr wdata delay srdata | bus baddr be bwdata we | err rdata stall req
        run(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 1, 32'hDEADBEEF,
            1'b1, 32'h104, 4'b1111, 32'h0, 1'b0, 1'b0, 32'hDEADBEEF, 2, 1);
        run(1'b0, 1'b1, 3'b000, 32'h203, 32'hA5, 3, 32'h11111111,
            1'b1, 32'h200, 4'b1000, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 4, 3);
        run(1'b0, 1'b1, 3'b001, 32'h2, 32'h1234, 1, 32'h22222222,
            1'b1, 32'h0, 4'b1100, 32'h12341234, 1'b1, 1'b0, 32'h0, 2, 1);
        run(1'b1, 1'b0, 3'b101, 32'h0, 32'hFFFF, 2, 32'h0000BEEF,
            1'b1, 32'h0, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0000BEEF, 3, 2);
        run(1'b0, 1'b1, 3'b010, 32'h8, 32'h89ABCDEF, 2, 32'h33333333,
            1'b1, 32'h8, 4'b1111, 32'h89ABCDEF, 1'b1, 1'b0, 32'h0, 3, 2);
        run(1'b0, 1'b1, 3'b000, 32'h1, 32'hFFFFFF3C, 1, 32'h0,
            1'b1, 32'h0, 4'b0010, 32'h3C3C3C3C, 1'b1, 1'b0, 32'h0, 2, 1);
        // Load and store both set: treated as a load.
        run(1'b1, 1'b1, 3'b010, 32'h10, 32'h55555555, 1, 32'h0BADF00D,
            1'b1, 32'h10, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h0BADF00D, 2, 1);
        // No ack: abandoned after 4 REQ cycles.
        run(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 0, 32'h0,
            1'b1, 32'h40, 4'b1111, 32'h0, 1'b0, 1'b1, 32'h0, 5, 4);

        // Asynchronous reset in the second REQ cycle.
        bus_q.push_back('{addr: 32'h60, wdata: 32'h0, be: 4'b1111, we: 1'b0});
        slv_delay = 0;
        @(posedge i_clk);
        #1;
        i_mem_valid = 1'b1;
        i_is_load   = 1'b1;
        i_funct3    = 3'b010;
        i_addr      = 32'h60;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        chk("req_before_rst", {31'h0, o_bus_req}, 32'd1);
        i_rst       = 1'b1;
        i_mem_valid = 1'b0;
        i_is_load   = 1'b0;
        #1;
        chk("rst_async_bus_req", {31'h0, o_bus_req}, 32'd0);
        chk("rst_async_stall", {31'h0, o_stall}, 32'd0);
        chk("rst_async_addr", o_addr, 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;

        run(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 1, 32'hCAFEF00D,
            1'b1, 32'h80, 4'b1111, 32'h0, 1'b0, 1'b0, 32'hCAFEF00D, 2, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        run(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h12345678,
            1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 1'b1, 32'h0, 1, 0);
`else
        run(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 1, 32'h12345678,
            1'b1, 32'h100, 4'b1111, 32'h0, 1'b0, 1'b0, 32'h12345678, 2, 1);
`endif

        repeat (3) @(posedge i_clk);
        #1;
        chk("done_q_drained", done_q.size(), 32'd0);
        chk("bus_q_drained", bus_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
